// File: rtl/chase_speed_encoder.sv
// Rotary-encoder and push-button front end for the fading chaser: synchronises,
// debounces and decodes the raw pins into a saturating speed code and a direction bit.
module chase_speed_encoder #(
  parameter int DEBOUNCE_COUNT   = 1000,
  parameter int STEPS_PER_DETENT = 4,
  parameter int SPEED_RESET      = 3,
  parameter int DIR_RESET        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       btn,
  output logic [2:0] speed,
  output logic       direction,
  output logic       speed_changed,
  output logic       quad_err
);

  // Channel order is {btn, A, B}; reset values match the idle pin levels.
  localparam logic [2:0]        PIN_IDLE     = 3'b011;
  localparam logic [15:0]       DB_LAST      = 16'(DEBOUNCE_COUNT - 1);
  localparam logic signed [2:0] ACC_FWD_LAST = 3'(STEPS_PER_DETENT - 1);
  localparam logic signed [2:0] ACC_REV_LAST = 3'(1 - STEPS_PER_DETENT);

  typedef enum logic [1:0] {
    QS_NONE = 2'd0,
    QS_FWD  = 2'd1,
    QS_REV  = 2'd2,
    QS_ERR  = 2'd3
  } quad_step_t;

  function automatic quad_step_t quad_classify(input logic [1:0] prev_ab,
                                               input logic [1:0] cur_ab);
    quad_step_t step;
    case ({prev_ab, cur_ab})
      4'b1110, 4'b1000, 4'b0001, 4'b0111: step = QS_FWD;
      4'b1101, 4'b0100, 4'b0010, 4'b1011: step = QS_REV;
      4'b1100, 4'b0011, 4'b1001, 4'b0110: step = QS_ERR;
      default:                            step = QS_NONE;
    endcase
    return step;
  endfunction

  logic [2:0]        w_pins;
  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_db;
  logic [15:0]       r_cnt [3];
  logic [1:0]        r_prev_ab;
  logic signed [2:0] r_acc;
  logic [2:0]        r_speed;
  logic              r_direction;
  logic              r_speed_changed;
  logic              r_quad_err;
  logic              r_btn_prev;

  quad_step_t        w_step;
  logic signed [2:0] w_acc_next;
  logic              w_step_up;
  logic              w_step_dn;
  logic [2:0]        w_speed_next;
  logic              w_btn_rise;

  assign w_pins = {btn, enc_a, enc_b};

  // Two-flop synchronisers for all three raw pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= PIN_IDLE;
      r_sync2 <= PIN_IDLE;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel debouncers: the output follows only after DEBOUNCE_COUNT stable cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db <= PIN_IDLE;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= 16'd0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= 16'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign w_step     = quad_classify(r_prev_ab, r_db[1:0]);
  assign w_btn_rise = r_db[2] & ~r_btn_prev;

  // Detent accumulation: limits are tested before the step so +/-4 never wraps in 3 bits.
  always_comb begin
    w_acc_next = r_acc;
    w_step_up  = 1'b0;
    w_step_dn  = 1'b0;
    case (w_step)
      QS_FWD: begin
        if (r_acc == ACC_FWD_LAST) begin
          w_acc_next = 3'sd0;
          w_step_up  = 1'b1;
        end else begin
          w_acc_next = r_acc + 3'sd1;
        end
      end
      QS_REV: begin
        if (r_acc == ACC_REV_LAST) begin
          w_acc_next = 3'sd0;
          w_step_dn  = 1'b1;
        end else begin
          w_acc_next = r_acc - 3'sd1;
        end
      end
      QS_ERR: begin
        w_acc_next = 3'sd0;
      end
      default: begin
        w_acc_next = r_acc;
      end
    endcase
  end

  // Saturating speed update.
  always_comb begin
    w_speed_next = r_speed;
    if (w_step_up && (r_speed != 3'd7)) begin
      w_speed_next = r_speed + 3'd1;
    end else if (w_step_dn && (r_speed != 3'd0)) begin
      w_speed_next = r_speed - 3'd1;
    end else begin
      w_speed_next = r_speed;
    end
  end

  // Decoder state, speed, direction and the registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_ab       <= 2'b11;
      r_acc           <= 3'sd0;
      r_speed         <= 3'(SPEED_RESET);
      r_direction     <= 1'(DIR_RESET);
      r_speed_changed <= 1'b0;
      r_quad_err      <= 1'b0;
      r_btn_prev      <= 1'b0;
    end else begin
      r_prev_ab       <= r_db[1:0];
      r_acc           <= w_acc_next;
      r_speed         <= w_speed_next;
      r_speed_changed <= (w_speed_next != r_speed);
      r_quad_err      <= (w_step == QS_ERR);
      r_btn_prev      <= r_db[2];
      r_direction     <= r_direction ^ w_btn_rise;
    end
  end

  assign speed         = r_speed;
  assign direction     = r_direction;
  assign speed_changed = r_speed_changed;
  assign quad_err      = r_quad_err;

endmodule

// File: tb/tb_chase_speed_encoder.sv
// Directed self-checking bench for chase_speed_encoder with DEBOUNCE_COUNT=4, STEPS_PER_DETENT=4.
module tb_chase_speed_encoder;

  logic       clk;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic       btn;
  logic [2:0] speed;
  logic       direction;
  logic       speed_changed;
  logic       quad_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int sc_cnt = 0;
  int qe_cnt = 0;
  int last_sc_cyc = -1;
  int ab_set_cyc = 0;

  chase_speed_encoder #(
    .DEBOUNCE_COUNT  (4),
    .STEPS_PER_DETENT(4),
    .SPEED_RESET     (3),
    .DIR_RESET       (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enc_a        (enc_a),
    .enc_b        (enc_b),
    .btn          (btn),
    .speed        (speed),
    .direction    (direction),
    .speed_changed(speed_changed),
    .quad_err     (quad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sample pre-edge values, then advance the cycle count.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      if (speed_changed === 1'b1) begin
        sc_cnt++;
        last_sc_cyc = cyc;
      end
      if (quad_err === 1'b1) qe_cnt++;
    end
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller is at a negedge; pins change here and are held for n cycles.
  task automatic step_ab(input logic [1:0] ab, input int n);
    enc_a = ab[1];
    enc_b = ab[0];
    ab_set_cyc = cyc;
    hold(n);
  endtask

  task automatic cw_detent();
    step_ab(2'b10, 10);
    step_ab(2'b00, 10);
    step_ab(2'b01, 10);
    step_ab(2'b11, 10);
  endtask

  task automatic ccw_detent();
    step_ab(2'b01, 10);
    step_ab(2'b00, 10);
    step_ab(2'b10, 10);
    step_ab(2'b11, 10);
  endtask

  initial begin
    reset = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b1;
    btn   = 1'b0;
    hold(3);
    check_eq("rst_speed", speed, 3);
    check_eq("rst_dir", direction, 1);
    check_eq("rst_sc", speed_changed, 0);
    check_eq("rst_qe", quad_err, 0);

    reset = 1'b1;
    hold(50);
    check_eq("idle_speed", speed, 3);
    check_eq("idle_dir", direction, 1);
    check_eq("idle_sc_cnt", sc_cnt, 0);
    check_eq("idle_qe_cnt", qe_cnt, 0);

    // One CW detent; pulse lands DEBOUNCE_COUNT+3 cycles after the final pin edge.
    cw_detent();
    check_eq("det1_speed", speed, 4);
    check_eq("det1_sc_cnt", sc_cnt, 1);
    check_eq("det1_latency", last_sc_cyc - ab_set_cyc, 7);

    sc_cnt = 0;
    repeat (5) cw_detent();
    check_eq("sat_speed", speed, 7);
    check_eq("sat_sc_cnt", sc_cnt, 3);
    sc_cnt = 0;
    ccw_detent();
    check_eq("rev_speed", speed, 6);
    check_eq("rev_sc_cnt", sc_cnt, 1);

    // Short glitches are rejected, a 6-cycle button pulse is accepted.
    sc_cnt = 0;
    enc_a = 1'b0;
    hold(3);
    enc_a = 1'b1;
    hold(20);
    btn = 1'b1;
    hold(3);
    btn = 1'b0;
    hold(20);
    check_eq("glitch_speed", speed, 6);
    check_eq("glitch_dir", direction, 1);
    check_eq("glitch_sc_cnt", sc_cnt, 0);
    check_eq("glitch_qe_cnt", qe_cnt, 0);
    btn = 1'b1;
    hold(6);
    btn = 1'b0;
    hold(20);
    check_eq("pulse6_dir", direction, 0);

    // Illegal jumps: errors pulse and the accumulator restarts from zero.
    step_ab(2'b10, 10);
    step_ab(2'b00, 10);
    step_ab(2'b11, 10);
    step_ab(2'b00, 10);
    check_eq("jump_qe_cnt", qe_cnt, 2);
    check_eq("jump_speed", speed, 6);
    step_ab(2'b01, 10);
    step_ab(2'b11, 10);
    check_eq("half_speed", speed, 6);
    step_ab(2'b10, 10);
    step_ab(2'b00, 10);
    check_eq("full_speed", speed, 7);
    check_eq("full_sc_cnt", sc_cnt, 1);
    step_ab(2'b11, 10);
    check_eq("jump2_qe_cnt", qe_cnt, 3);
    check_eq("jump2_speed", speed, 7);

    // Button: toggle lands DEBOUNCE_COUNT+3 cycles after the press; holding toggles once.
    btn = 1'b1;
    hold(6);
    check_eq("press1_early", direction, 0);
    hold(1);
    check_eq("press1_edge", direction, 1);
    hold(13);
    check_eq("press1_hold", direction, 1);
    btn = 1'b0;
    hold(20);
    check_eq("release1", direction, 1);
    btn = 1'b1;
    hold(20);
    check_eq("press2", direction, 0);
    btn = 1'b0;
    hold(20);
    check_eq("release2", direction, 0);

    // Reset in the middle of a detent, then finish the partial detent.
    step_ab(2'b10, 10);
    step_ab(2'b00, 10);
    reset = 1'b0;
    #1;
    check_eq("midrst_speed", speed, 3);
    check_eq("midrst_dir", direction, 1);
    hold(3);
    reset = 1'b1;
    sc_cnt = 0;
    qe_cnt = 0;
    step_ab(2'b01, 10);
    step_ab(2'b11, 10);
    check_eq("postrst_speed", speed, 3);
    check_eq("postrst_sc_cnt", sc_cnt, 0);
    check_eq("postrst_qe_cnt", qe_cnt, 0);
    step_ab(2'b10, 10);
    step_ab(2'b00, 10);
    check_eq("postrst_half", speed, 3);
    step_ab(2'b01, 10);
    step_ab(2'b11, 10);
    check_eq("postrst_full", speed, 4);
    check_eq("postrst_sc1", sc_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
